// File: rtl/tl_pkg.sv
// TileLink-UL opcode constants and beat-count helpers shared by the interconnect blocks.
package tl_pkg;

    localparam logic [2:0] TL_PUT_FULL    = 3'd0;
    localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] TL_GET         = 3'd4;
    localparam logic [2:0] TL_ACK         = 3'd0;
    localparam logic [2:0] TL_ACK_DATA    = 3'd1;

    // Wide enough for a 2^15-byte message on an 8-bit bus.
    localparam int unsigned BEAT_W = 16;

    typedef enum logic {StIdle, StBurst} arb_state_e;

    function automatic logic [BEAT_W-1:0] tl_burst_len(input logic [3:0] size,
                                                       input int unsigned b);
        logic [31:0] n;
        n = (32'd1 << size) / b;
        if (n == 32'd0) n = 32'd1;
        return BEAT_W'(n);
    endfunction

    // A-channel beats per message.
    function automatic logic [BEAT_W-1:0] tl_beats(input logic [2:0] opcode,
                                                   input logic [3:0] size,
                                                   input int unsigned b);
        logic [BEAT_W-1:0] n;
        case (opcode)
            TL_PUT_FULL, TL_PUT_PARTIAL: n = tl_burst_len(size, b);
            TL_GET:                      n = BEAT_W'(1);
            default:                     n = BEAT_W'(1);
        endcase
        return n;
    endfunction

    // D-channel beats per message.
    function automatic logic [BEAT_W-1:0] tl_d_beats(input logic [2:0] opcode,
                                                     input logic [3:0] size,
                                                     input int unsigned b);
        logic [BEAT_W-1:0] n;
        case (opcode)
            TL_ACK_DATA: n = tl_burst_len(size, b);
            TL_ACK:      n = BEAT_W'(1);
            default:     n = BEAT_W'(1);
        endcase
        return n;
    endfunction

endpackage

// File: rtl/tl_rr_pick.sv
// Round-robin priority picker: first requester at or after ptr, wrapping.
module tl_rr_pick #(
    parameter int unsigned N    = 2,
    parameter int unsigned IW   = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          valid
);

    logic [IW-1:0] idx;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = IW'((32'(ptr) + k) % N);
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tilelink_rr_arbiter.sv
// Round-robin NUM_M:1 TileLink-UL arbiter with burst lock, source-index D routing
// and a per-master outstanding-request limiter.
module tilelink_rr_arbiter
    import tl_pkg::*;
#(
    parameter int unsigned NUM_M   = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SRC_W   = 1,
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_M)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_M*3-1:0]         m_a_opcode,
    input  logic [NUM_M*3-1:0]         m_a_param,
    input  logic [NUM_M*4-1:0]         m_a_size,
    input  logic [NUM_M*SRC_W-1:0]     m_a_source,
    input  logic [NUM_M*ADDR_W-1:0]    m_a_address,
    input  logic [NUM_M*DATA_W/8-1:0]  m_a_mask,
    input  logic [NUM_M*DATA_W-1:0]    m_a_data,
    input  logic [NUM_M-1:0]           m_a_corrupt,
    input  logic [NUM_M-1:0]           m_a_valid,
    output logic [NUM_M-1:0]           m_a_ready,
    output logic [NUM_M*3-1:0]         m_d_opcode,
    output logic [NUM_M*2-1:0]         m_d_param,
    output logic [NUM_M*4-1:0]         m_d_size,
    output logic [NUM_M*SRC_W-1:0]     m_d_source,
    output logic [NUM_M-1:0]           m_d_denied,
    output logic [NUM_M*DATA_W-1:0]    m_d_data,
    output logic [NUM_M-1:0]           m_d_corrupt,
    output logic [NUM_M-1:0]           m_d_valid,
    input  logic [NUM_M-1:0]           m_d_ready,
    output logic [2:0]                 s_a_opcode,
    output logic [2:0]                 s_a_param,
    output logic [3:0]                 s_a_size,
    output logic [SRC_W+IDX_W-1:0]     s_a_source,
    output logic [ADDR_W-1:0]          s_a_address,
    output logic [DATA_W/8-1:0]        s_a_mask,
    output logic [DATA_W-1:0]          s_a_data,
    output logic                       s_a_corrupt,
    output logic                       s_a_valid,
    input  logic                       s_a_ready,
    input  logic [2:0]                 s_d_opcode,
    input  logic [1:0]                 s_d_param,
    input  logic [3:0]                 s_d_size,
    input  logic [SRC_W+IDX_W-1:0]     s_d_source,
    input  logic                       s_d_denied,
    input  logic [DATA_W-1:0]          s_d_data,
    input  logic                       s_d_corrupt,
    input  logic                       s_d_valid,
    output logic                       s_d_ready
);

    localparam int unsigned B     = DATA_W / 8;
    localparam int unsigned OUT_W = 4;

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  lock_q, lock_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [BEAT_W-1:0] d_cnt_q, d_cnt_d;
    logic [OUT_W-1:0]  out_cnt_q [NUM_M];
    logic [OUT_W-1:0]  out_cnt_d [NUM_M];
    logic              err_q, err_d;

    logic [NUM_M-1:0]  req, pick_gnt;
    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx, grant_idx;
    logic              grant_valid;
    logic              a_hs, a_last, d_hs, d_last, d_bad;
    logic [BEAT_W-1:0] a_beats, d_beats;
    logic [IDX_W-1:0]  d_idx;

    always_comb begin
        for (int unsigned i = 0; i < NUM_M; i++) begin
            req[i] = m_a_valid[i] && (out_cnt_q[i] < OUT_W'(MAX_OUT));
        end
    end

    tl_rr_pick #(
        .N  (NUM_M),
        .IW (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (rr_ptr_q),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    // A mux; during a burst the locked master stays connected even if it drops valid.
    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < NUM_M; i++) begin
            if (pick_gnt[i]) pick_idx = IDX_W'(i);
        end
        grant_idx   = (state_q == StBurst) ? lock_q : pick_idx;
        grant_valid = (state_q == StBurst) || pick_valid;

        s_a_opcode  = '0;
        s_a_param   = '0;
        s_a_size    = '0;
        s_a_source  = '0;
        s_a_address = '0;
        s_a_mask    = '0;
        s_a_data    = '0;
        s_a_corrupt = 1'b0;
        s_a_valid   = 1'b0;
        m_a_ready   = '0;
        for (int unsigned i = 0; i < NUM_M; i++) begin
            if (grant_valid && grant_idx == IDX_W'(i)) begin
                s_a_opcode  = m_a_opcode[i*3 +: 3];
                s_a_param   = m_a_param[i*3 +: 3];
                s_a_size    = m_a_size[i*4 +: 4];
                s_a_source  = {IDX_W'(i), m_a_source[i*SRC_W +: SRC_W]};
                s_a_address = m_a_address[i*ADDR_W +: ADDR_W];
                s_a_mask    = m_a_mask[i*B +: B];
                s_a_data    = m_a_data[i*DATA_W +: DATA_W];
                s_a_corrupt = m_a_corrupt[i];
                s_a_valid   = m_a_valid[i];
                m_a_ready[i] = s_a_ready;
            end
        end
    end

    // D routing by the index bits appended to the source on the way out.
    always_comb begin
        d_idx      = s_d_source[SRC_W+IDX_W-1:SRC_W];
        d_bad      = ({1'b0, d_idx} >= (IDX_W+1)'(NUM_M));
        s_d_ready  = d_bad ? 1'b1 : m_d_ready[d_idx];
        m_d_opcode = {NUM_M{s_d_opcode}};
        m_d_param  = {NUM_M{s_d_param}};
        m_d_size   = {NUM_M{s_d_size}};
        m_d_source = {NUM_M{s_d_source[SRC_W-1:0]}};
        m_d_denied = {NUM_M{s_d_denied}};
        m_d_data   = {NUM_M{s_d_data}};
        m_d_corrupt = {NUM_M{s_d_corrupt}};
        for (int unsigned i = 0; i < NUM_M; i++) begin
            m_d_valid[i] = s_d_valid && !d_bad && (d_idx == IDX_W'(i));
        end
    end

    always_comb begin
        a_hs    = s_a_valid && s_a_ready;
        a_beats = tl_beats(s_a_opcode, s_a_size, B);
        a_last  = (state_q == StIdle) ? (a_beats == BEAT_W'(1)) : (beat_cnt_q == BEAT_W'(1));
        d_hs    = s_d_valid && s_d_ready && !d_bad;
        d_beats = tl_d_beats(s_d_opcode, s_d_size, B);
        d_last  = (d_cnt_q == '0) ? (d_beats == BEAT_W'(1)) : (d_cnt_q == BEAT_W'(1));

        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        beat_cnt_d = beat_cnt_q;
        d_cnt_d    = d_cnt_q;
        err_d      = err_q || (s_d_valid && d_bad);

        if (a_hs) begin
            unique case (state_q)
                StIdle: begin
                    if (!a_last) begin
                        state_d    = StBurst;
                        beat_cnt_d = a_beats - BEAT_W'(1);
                        lock_d     = grant_idx;
                    end
                end
                StBurst: begin
                    beat_cnt_d = beat_cnt_q - BEAT_W'(1);
                    if (a_last) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
            if (a_last) begin
                rr_ptr_d = (grant_idx == IDX_W'(NUM_M - 1)) ? '0 : grant_idx + IDX_W'(1);
            end
        end

        if (d_hs) begin
            if (d_cnt_q == '0) d_cnt_d = d_last ? '0 : d_beats - BEAT_W'(1);
            else               d_cnt_d = d_cnt_q - BEAT_W'(1);
        end

        // Simultaneous issue and retire for one master leave its count unchanged.
        for (int unsigned i = 0; i < NUM_M; i++) begin
            logic inc, dec;
            inc = a_hs && a_last && (grant_idx == IDX_W'(i));
            dec = d_hs && d_last && (d_idx == IDX_W'(i));
            out_cnt_d[i] = out_cnt_q[i];
            if (inc && !dec)                             out_cnt_d[i] = out_cnt_q[i] + OUT_W'(1);
            else if (dec && !inc && out_cnt_q[i] != '0) out_cnt_d[i] = out_cnt_q[i] - OUT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            lock_q     <= '0;
            beat_cnt_q <= '0;
            d_cnt_q    <= '0;
            err_q      <= 1'b0;
            for (int unsigned i = 0; i < NUM_M; i++) out_cnt_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            beat_cnt_q <= beat_cnt_d;
            d_cnt_q    <= d_cnt_d;
            err_q      <= err_d;
            for (int unsigned i = 0; i < NUM_M; i++) out_cnt_q[i] <= out_cnt_d[i];
        end
    end

endmodule

// File: tb/tb_tilelink_rr_arbiter.sv
// Directed bench for tilelink_rr_arbiter with a cycle-by-cycle transaction-level model.
module tb_tilelink_rr_arbiter;

    localparam int NUM_M = 2, ADDR_W = 32, DATA_W = 32, SRC_W = 1, MAX_OUT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  m_a_opcode, m_a_param;
    logic [7:0]  m_a_size;
    logic [1:0]  m_a_source;
    logic [63:0] m_a_address;
    logic [7:0]  m_a_mask;
    logic [63:0] m_a_data;
    logic [1:0]  m_a_corrupt, m_a_valid, m_a_ready;
    logic [5:0]  m_d_opcode;
    logic [3:0]  m_d_param;
    logic [7:0]  m_d_size;
    logic [1:0]  m_d_source, m_d_denied, m_d_corrupt, m_d_valid, m_d_ready;
    logic [63:0] m_d_data;
    logic [2:0]  s_a_opcode, s_a_param;
    logic [3:0]  s_a_size;
    logic [1:0]  s_a_source;
    logic [31:0] s_a_address, s_a_data;
    logic [3:0]  s_a_mask;
    logic        s_a_corrupt, s_a_valid, s_a_ready;
    logic [2:0]  s_d_opcode;
    logic [1:0]  s_d_param;
    logic [3:0]  s_d_size;
    logic [1:0]  s_d_source;
    logic        s_d_denied, s_d_corrupt, s_d_valid, s_d_ready;
    logic [31:0] s_d_data;

    int n_assert = 0;
    int n_fail   = 0;

    tilelink_rr_arbiter #(
        .NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m_a_opcode(m_a_opcode), .m_a_param(m_a_param), .m_a_size(m_a_size),
        .m_a_source(m_a_source), .m_a_address(m_a_address), .m_a_mask(m_a_mask),
        .m_a_data(m_a_data), .m_a_corrupt(m_a_corrupt), .m_a_valid(m_a_valid),
        .m_a_ready(m_a_ready),
        .m_d_opcode(m_d_opcode), .m_d_param(m_d_param), .m_d_size(m_d_size),
        .m_d_source(m_d_source), .m_d_denied(m_d_denied), .m_d_data(m_d_data),
        .m_d_corrupt(m_d_corrupt), .m_d_valid(m_d_valid), .m_d_ready(m_d_ready),
        .s_a_opcode(s_a_opcode), .s_a_param(s_a_param), .s_a_size(s_a_size),
        .s_a_source(s_a_source), .s_a_address(s_a_address), .s_a_mask(s_a_mask),
        .s_a_data(s_a_data), .s_a_corrupt(s_a_corrupt), .s_a_valid(s_a_valid),
        .s_a_ready(s_a_ready),
        .s_d_opcode(s_d_opcode), .s_d_param(s_d_param), .s_d_size(s_d_size),
        .s_d_source(s_d_source), .s_d_denied(s_d_denied), .s_d_data(s_d_data),
        .s_d_corrupt(s_d_corrupt), .s_d_valid(s_d_valid), .s_d_ready(s_d_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: transaction-level view of grants, burst progress and outstanding counts.
    int mdl_lock, mdl_rem, mdl_ptr, mdl_drem;
    int mdl_out [NUM_M];

    function automatic int burst_len(input int size);
        int n;
        n = (1 << size) / (DATA_W / 8);
        return (n < 1) ? 1 : n;
    endfunction

    function automatic int a_beats_of(input int op, input int size);
        return (op == 0 || op == 1) ? burst_len(size) : 1;
    endfunction

    function automatic int d_beats_of(input int op, input int size);
        return (op == 1) ? burst_len(size) : 1;
    endfunction

    initial begin
        int g, di, n, p_g, p_di, p_aop, p_asz, p_dop, p_dsz;
        bit p_ahs, p_dhs;
        logic [1:0] exp_rdy;
        mdl_lock = -1; mdl_rem = 0; mdl_ptr = 0; mdl_drem = 0;
        mdl_out[0] = 0; mdl_out[1] = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mdl_lock = -1; mdl_rem = 0; mdl_ptr = 0; mdl_drem = 0;
                mdl_out[0] = 0; mdl_out[1] = 0;
            end
            g = -1;
            if (mdl_lock >= 0) g = mdl_lock;
            else begin
                for (int k = 0; k < NUM_M; k++) begin
                    int i;
                    i = (mdl_ptr + k) % NUM_M;
                    if (g < 0 && m_a_valid[i] && mdl_out[i] < MAX_OUT) g = i;
                end
            end
            exp_rdy = (g >= 0 && s_a_ready) ? (2'b01 << g) : 2'b00;
            chk("mdl_a_ready", m_a_ready, exp_rdy);
            chk("mdl_a_valid", s_a_valid, (g >= 0) ? m_a_valid[g] : 1'b0);
            chk("mdl_a_source", s_a_source, (g >= 0) ? {g[0], m_a_source[g]} : 2'b00);
            chk("mdl_a_address", s_a_address, (g >= 0) ? m_a_address[g*32 +: 32] : 32'h0);
            di = s_d_source[1];
            chk("mdl_d_valid", m_d_valid, s_d_valid ? (2'b01 << di) : 2'b00);
            chk("mdl_d_ready", s_d_ready, m_d_ready[di]);
            chk("mdl_d_source", m_d_source, {2{s_d_source[0]}});
            p_ahs = (g >= 0) && m_a_valid[g] && s_a_ready;
            p_g   = g;
            p_aop = (g >= 0) ? int'(m_a_opcode[g*3 +: 3]) : 0;
            p_asz = (g >= 0) ? int'(m_a_size[g*4 +: 4]) : 0;
            p_dhs = s_d_valid && m_d_ready[di];
            p_di  = di;
            p_dop = int'(s_d_opcode);
            p_dsz = int'(s_d_size);
            @(posedge clk);
            if (rst_n) begin
                if (p_ahs) begin
                    if (mdl_lock < 0) begin
                        n = a_beats_of(p_aop, p_asz);
                        if (n == 1) begin
                            mdl_out[p_g]++;
                            mdl_ptr = (p_g + 1) % NUM_M;
                        end else begin
                            mdl_lock = p_g;
                            mdl_rem  = n - 1;
                        end
                    end else begin
                        mdl_rem--;
                        if (mdl_rem == 0) begin
                            mdl_out[p_g]++;
                            mdl_ptr  = (p_g + 1) % NUM_M;
                            mdl_lock = -1;
                        end
                    end
                end
                if (p_dhs) begin
                    if (mdl_drem == 0) begin
                        n = d_beats_of(p_dop, p_dsz);
                        if (n == 1) mdl_out[p_di]--;
                        else        mdl_drem = n - 1;
                    end else begin
                        mdl_drem--;
                        if (mdl_drem == 0) mdl_out[p_di]--;
                    end
                end
            end
        end
    end

    task automatic set_a(input int i, input logic [2:0] op, input logic [3:0] sz,
                         input logic src, input logic [31:0] addr);
        m_a_opcode[i*3 +: 3]   = op;
        m_a_param[i*3 +: 3]    = 3'd0;
        m_a_size[i*4 +: 4]     = sz;
        m_a_source[i]          = src;
        m_a_address[i*32 +: 32] = addr;
        m_a_mask[i*4 +: 4]     = 4'hF;
        m_a_data[i*32 +: 32]   = addr ^ 32'hA5A5_0000;
        m_a_corrupt[i]         = 1'b0;
        m_a_valid[i]           = 1'b1;
    endtask

    // Drive one D beat and hold it until the arbiter accepts it (bounded).
    task automatic send_d(input logic [2:0] op, input logic [3:0] sz, input logic [1:0] src);
        int t;
        s_d_opcode = op; s_d_size = sz; s_d_source = src; s_d_data = 32'h1234_0000;
        s_d_valid  = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!s_d_ready && t < 20);
        chk("d_accept", s_d_ready, 1'b1);
        @(posedge clk); #1;
        s_d_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        m_a_opcode = '0; m_a_param = '0; m_a_size = '0; m_a_source = '0; m_a_address = '0;
        m_a_mask = '0; m_a_data = '0; m_a_corrupt = '0; m_a_valid = '0;
        m_d_ready = '0; s_a_ready = 1'b0;
        s_d_opcode = '0; s_d_param = '0; s_d_size = '0; s_d_source = '0; s_d_denied = 1'b0;
        s_d_data = '0; s_d_corrupt = 1'b0; s_d_valid = 1'b0;

        @(negedge clk);
        chk("reset_s_a_valid", s_a_valid, 1'b0);
        chk("reset_m_a_ready", m_a_ready, 2'b00);
        chk("reset_m_d_valid", m_d_valid, 2'b00);
        @(posedge clk); #1;
        rst_n = 1'b1; s_a_ready = 1'b1; m_d_ready = 2'b11;

        // Alternating single-beat Gets.
        set_a(0, 3'd4, 4'd2, 1'b0, 32'h1000);
        set_a(1, 3'd4, 4'd2, 1'b0, 32'h2000);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr_source", s_a_source, (k % 2 == 1) ? 2'b10 : 2'b00);
            chk("rr_ready", m_a_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
        end
        @(posedge clk); #1;
        m_a_valid = 2'b00;
        send_d(3'd0, 4'd2, 2'b00);
        send_d(3'd0, 4'd2, 2'b00);
        send_d(3'd0, 4'd2, 2'b10);
        send_d(3'd0, 4'd2, 2'b10);

        // 4-beat PutFullData from master 0; master 1 arrives at beat 2.
        set_a(0, 3'd0, 4'd4, 1'b0, 32'h1100);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            chk("burst_lock_ready", m_a_ready, 2'b01);
            chk("burst_lock_source", s_a_source, 2'b00);
            if (b == 0) begin
                @(posedge clk); #1;
                set_a(1, 3'd4, 4'd2, 1'b1, 32'h2100);
            end
        end
        @(posedge clk); #1;
        m_a_valid[0] = 1'b0;
        @(negedge clk);
        chk("after_burst_ready", m_a_ready, 2'b10);
        chk("after_burst_source", s_a_source, 2'b11);
        @(posedge clk); #1;
        m_a_valid[1] = 1'b0;

        // 4-beat AccessAckData routed to master 1.
        s_d_opcode = 3'd1; s_d_size = 4'd4; s_d_source = 2'b10; s_d_valid = 1'b1;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            chk("ackdata_valid", m_d_valid, 2'b10);
            chk("ackdata_source", m_d_source, 2'b00);
        end
        @(posedge clk); #1;
        s_d_valid = 1'b0;
        @(negedge clk);
        chk("ackdata_done", m_d_valid, 2'b00);
        @(posedge clk); #1;
        send_d(3'd0, 4'd2, 2'b00);

        // Outstanding limit on master 0.
        set_a(0, 3'd4, 4'd2, 1'b0, 32'h1200);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("limit_fill", m_a_ready, 2'b01);
        end
        @(posedge clk); #1;
        set_a(1, 3'd4, 4'd2, 1'b0, 32'h2200);
        @(negedge clk);
        chk("limit_skip", m_a_ready, 2'b10);
        @(posedge clk); #1;
        m_a_valid[1] = 1'b0;
        @(negedge clk);
        chk("limit_stall_ready", m_a_ready, 2'b00);
        chk("limit_stall_valid", s_a_valid, 1'b0);
        @(posedge clk); #1;
        s_d_opcode = 3'd0; s_d_size = 4'd2; s_d_source = 2'b00; s_d_valid = 1'b1;
        @(negedge clk);
        chk("limit_ack_valid", m_d_valid, 2'b01);
        chk("limit_still_stalled", m_a_ready, 2'b00);
        @(posedge clk); #1;
        s_d_valid = 1'b0;
        @(negedge clk);
        chk("limit_fifth_grant", m_a_ready, 2'b01);
        @(posedge clk); #1;
        m_a_valid[0] = 1'b0;

        // D backpressure from master 0.
        m_d_ready = 2'b10;
        s_d_opcode = 3'd0; s_d_size = 4'd2; s_d_source = 2'b00; s_d_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_s_d_ready", s_d_ready, 1'b0);
            chk("bp_m_d_valid", m_d_valid, 2'b01);
            @(posedge clk); #1;
        end
        m_d_ready = 2'b11;
        @(negedge clk);
        chk("bp_release", s_d_ready, 1'b1);
        @(posedge clk); #1;
        s_d_valid = 1'b0;

        // Reset during beat 2 of a 4-beat Put.
        set_a(0, 3'd0, 4'd4, 1'b0, 32'h1300);
        @(negedge clk);
        chk("rst_burst_beat1", m_a_ready, 2'b01);
        @(negedge clk);
        chk("rst_burst_beat2", m_a_ready, 2'b01);
        #1;
        rst_n = 1'b0;
        m_a_valid = 2'b00;
        #1;
        chk("rst_m_a_ready", m_a_ready, 2'b00);
        chk("rst_s_a_valid", s_a_valid, 1'b0);
        chk("rst_s_a_address", s_a_address, 32'h0);
        chk("rst_s_a_data", s_a_data, 32'h0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_a(0, 3'd4, 4'd2, 1'b0, 32'h1400);
        set_a(1, 3'd4, 4'd2, 1'b0, 32'h2400);
        @(negedge clk);
        chk("post_rst_first_ready", m_a_ready, 2'b01);
        chk("post_rst_first_source", s_a_source, 2'b00);
        @(negedge clk);
        chk("post_rst_second_ready", m_a_ready, 2'b10);
        @(posedge clk); #1;
        m_a_valid = 2'b00;
        @(negedge clk);
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
